// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the control sequencer
// Contents: STATE_* state encodings, OP_* opcodes, CTRL_* bus register
// addresses, and decode_state() which maps a raw bus value onto a legal state.
package ctrl_pkg;

    localparam int CTRL_STATE_W = 4;

    typedef enum logic [CTRL_STATE_W-1:0] {
        STATE_RESET    = 4'd0,
        STATE_HALT     = 4'd1,
        STATE_FETCH    = 4'd2,
        STATE_REGLOAD  = 4'd3,
        STATE_ALUOP    = 4'd4,
        STATE_REGSTORE = 4'd5,
        STATE_LOAD     = 4'd6,
        STATE_STORE    = 4'd7,
        STATE_NEXT     = 4'd8
    } ctrl_state_e;

    localparam logic [3:0] OP_HALT   = 4'd0;
    localparam logic [3:0] OP_LOAD   = 4'd1;
    localparam logic [3:0] OP_STORE  = 4'd2;
    localparam logic [3:0] OP_LOADLO = 4'd3;
    localparam logic [3:0] OP_LOADHI = 4'd4;
    localparam logic [3:0] OP_IN     = 4'd5;
    localparam logic [3:0] OP_OUT    = 4'd6;
    localparam logic [3:0] OP_JMP    = 4'd7;
    localparam logic [3:0] OP_BR     = 4'd8;

    localparam logic [7:0] CTRL_ADDR_STATE = 8'hF0;
    localparam logic [7:0] CTRL_ADDR_WAIT  = 8'hF1;

    // Encodings above STATE_NEXT do not exist; park them in HALT.
    function automatic ctrl_state_e decode_state(input logic [CTRL_STATE_W-1:0] v);
        if (v <= 4'(STATE_NEXT)) begin
            return ctrl_state_e'(v);
        end
        return STATE_HALT;
    endfunction

endpackage

// File: rtl/ctrl_dwell_timer.sv
// rtl/ctrl_dwell_timer.sv - loadable down-counter that sets the per-state dwell
// Ports: clk, rst_n (sync, active low), load_i/load_val_i (load wins over dec),
// dec_i (decrement, saturates at zero), zero_o (count is zero).
module ctrl_dwell_timer #(
    parameter int            W       = 8,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ctrl_seq.sv
// rtl/ctrl_seq.sv - multicycle CPU control sequencer with dwell, mem stall and bus access
// Ports: clk, rst_n (sync, active low); opcode/isaluop select the instruction path;
// mem_ready releases LOAD/STORE; bus_* is the register port (state at
// CTRL_STATE_ADDR, wait at CTRL_WAIT_ADDR, registered read data); do_* are
// one-cycle phase strobes; halted flags HALT; state is the current state.
module ctrl_seq
    import ctrl_pkg::*;
#(
    parameter int                 NIB_SIZE        = 4,
    parameter int                 ADDR_W          = 8,
    parameter int                 DATA_W          = 8,
    parameter int                 STATE_W         = 4,
    parameter int                 WAIT_W          = 8,
    parameter logic [WAIT_W-1:0]  DEFAULT_WAIT    = '0,
    parameter logic [ADDR_W-1:0]  CTRL_STATE_ADDR = CTRL_ADDR_STATE,
    parameter logic [ADDR_W-1:0]  CTRL_WAIT_ADDR  = CTRL_ADDR_WAIT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NIB_SIZE-1:0] opcode,
    input  logic                isaluop,
    input  logic                mem_ready,
    input  logic [ADDR_W-1:0]   bus_addr,
    input  logic                bus_read,
    input  logic                bus_write,
    input  logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W-1:0]   bus_rdata,
    output logic                bus_rvalid,
    output logic                do_fetch,
    output logic                do_regload,
    output logic                do_aluop,
    output logic                do_memload,
    output logic                do_memstore,
    output logic                do_regstore,
    output logic                do_next,
    output logic                do_reset,
    output logic                halted,
    output logic [STATE_W-1:0]  state
);

    ctrl_state_e        state_q, state_d, fsm_next;
    logic               entry_q, entry_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;

    logic state_wr, wait_wr, dwell_zero, mem_ok, advance;

    assign state_wr = bus_write && (bus_addr == CTRL_STATE_ADDR);
    assign wait_wr  = bus_write && (bus_addr == CTRL_WAIT_ADDR);

    // Only the memory phases wait on mem_ready; HALT never advances on its own.
    assign mem_ok  = ((state_q != STATE_LOAD) && (state_q != STATE_STORE)) || mem_ready;
    assign advance = dwell_zero && mem_ok && (state_q != STATE_HALT);

    ctrl_dwell_timer #(
        .W       (WAIT_W),
        .RST_VAL (DEFAULT_WAIT)
    ) u_dwell (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (state_wr || advance),
        .load_val_i (wait_q),
        .dec_i      (!dwell_zero),
        .zero_o     (dwell_zero)
    );

    always_comb begin
        fsm_next = STATE_HALT;
        case (state_q)
            STATE_RESET:   fsm_next = STATE_FETCH;
            STATE_FETCH:   fsm_next = STATE_REGLOAD;
            STATE_REGLOAD: begin
                if (isaluop) begin
                    fsm_next = STATE_ALUOP;
                end else begin
                    case (opcode)
                        OP_LOAD, OP_IN:     fsm_next = STATE_LOAD;
                        OP_STORE, OP_OUT:   fsm_next = STATE_STORE;
                        OP_LOADLO, OP_LOADHI: fsm_next = STATE_REGSTORE;
                        OP_JMP, OP_BR:      fsm_next = STATE_NEXT;
                        default:            fsm_next = STATE_HALT;
                    endcase
                end
            end
            STATE_ALUOP, STATE_LOAD:     fsm_next = STATE_REGSTORE;
            STATE_REGSTORE, STATE_STORE: fsm_next = STATE_NEXT;
            STATE_NEXT:                  fsm_next = STATE_FETCH;
            default:                     fsm_next = STATE_HALT;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        entry_d  = 1'b0;
        wait_d   = wait_q;
        rvalid_d = 1'b0;
        rdata_d  = '0;
        // A bus write of the state register beats the FSM in the same cycle.
        if (state_wr) begin
            state_d = decode_state(bus_wdata[STATE_W-1:0]);
            entry_d = 1'b1;
        end else if (advance) begin
            state_d = fsm_next;
            entry_d = 1'b1;
        end
        if (wait_wr) begin
            wait_d = bus_wdata[WAIT_W-1:0];
        end
        // Reads sample the current registers, so a same-cycle write is not visible.
        if (bus_read && (bus_addr == CTRL_STATE_ADDR)) begin
            rvalid_d = 1'b1;
            rdata_d  = DATA_W'(state_q);
        end else if (bus_read && (bus_addr == CTRL_WAIT_ADDR)) begin
            rvalid_d = 1'b1;
            rdata_d  = DATA_W'(wait_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= STATE_RESET;
            entry_q  <= 1'b1;
            wait_q   <= DEFAULT_WAIT;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            entry_q  <= entry_d;
            wait_q   <= wait_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Strobes fire on the first cycle of a visit and are masked while reset is held.
    assign do_reset    = rst_n && entry_q && (state_q == STATE_RESET);
    assign do_fetch    = rst_n && entry_q && (state_q == STATE_FETCH);
    assign do_regload  = rst_n && entry_q && (state_q == STATE_REGLOAD);
    assign do_aluop    = rst_n && entry_q && (state_q == STATE_ALUOP);
    assign do_regstore = rst_n && entry_q && (state_q == STATE_REGSTORE);
    assign do_memload  = rst_n && entry_q && (state_q == STATE_LOAD);
    assign do_memstore = rst_n && entry_q && (state_q == STATE_STORE);
    assign do_next     = rst_n && entry_q && (state_q == STATE_NEXT);
    assign halted      = rst_n && (state_q == STATE_HALT);

    assign state      = STATE_W'(state_q);
    assign bus_rdata  = rdata_q;
    assign bus_rvalid = rvalid_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// tb/tb_ctrl_seq.sv - self-checking bench for ctrl_seq
module tb_ctrl_seq;
    import ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] opcode = OP_LOAD;
    logic       isaluop = 1'b0;
    logic       mem_ready = 1'b1;
    logic [7:0] bus_addr = 8'h00;
    logic       bus_read = 1'b0;
    logic       bus_write = 1'b0;
    logic [7:0] bus_wdata = 8'h00;
    logic [7:0] bus_rdata;
    logic       bus_rvalid;
    logic       do_fetch, do_regload, do_aluop, do_memload, do_memstore;
    logic       do_regstore, do_next, do_reset, halted;
    logic [3:0] state;

    ctrl_seq dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .isaluop(isaluop),
        .mem_ready(mem_ready), .bus_addr(bus_addr), .bus_read(bus_read),
        .bus_write(bus_write), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_rvalid(bus_rvalid), .do_fetch(do_fetch), .do_regload(do_regload),
        .do_aluop(do_aluop), .do_memload(do_memload), .do_memstore(do_memstore),
        .do_regstore(do_regstore), .do_next(do_next), .do_reset(do_reset),
        .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endfunction

    // Strobes packed by state code; bit 1 (HALT) has no strobe.
    logic [8:0] dut_stb;
    assign dut_stb = {do_next, do_memstore, do_memload, do_regstore, do_aluop,
                      do_regload, do_fetch, 1'b0, do_reset};

    // ---------------- behavioural model ----------------
    localparam int DEF_WAIT = 0;
    int succ [9] = '{2, 1, 3, 0, 5, 8, 5, 8, 2};
    int op_dest [16];
    int m_state = 0, m_left = 0, m_wait = 0, m_rd = 0;
    bit m_new = 1'b0, m_rv = 1'b0, m_ok = 1'b0;

    initial begin
        for (int i = 0; i < 16; i++) op_dest[i] = 1;
        op_dest[OP_LOAD] = 6;   op_dest[OP_IN] = 6;
        op_dest[OP_STORE] = 7;  op_dest[OP_OUT] = 7;
        op_dest[OP_LOADLO] = 5; op_dest[OP_LOADHI] = 5;
        op_dest[OP_JMP] = 8;    op_dest[OP_BR] = 8;
    end

    always @(posedge clk) begin
        int ns, nl, nw, nrd;
        bit nn, nrv;
        if (!rst_n) begin
            ns = 0; nl = DEF_WAIT; nw = DEF_WAIT; nn = 1'b1; nrv = 1'b0; nrd = 0;
            m_ok <= 1'b1;
        end else begin
            ns = m_state; nl = m_left; nw = m_wait; nn = 1'b0;
            nrv = bus_read && (bus_addr == 8'hF0 || bus_addr == 8'hF1);
            nrd = !nrv ? 0 : (bus_addr == 8'hF0 ? m_state : m_wait);
            if (bus_write && bus_addr == 8'hF0) begin
                ns = (int'(bus_wdata[3:0]) > 8) ? 1 : int'(bus_wdata[3:0]);
                nl = m_wait; nn = 1'b1;
            end else if (m_left > 0) begin
                nl = m_left - 1;
            end else if (m_state != 1 && (!(m_state == 6 || m_state == 7) || mem_ready)) begin
                ns = (m_state == 3) ? (isaluop ? 4 : op_dest[opcode]) : succ[m_state];
                nl = m_wait; nn = 1'b1;
            end
            if (bus_write && bus_addr == 8'hF1) nw = int'(bus_wdata);
        end
        m_state <= ns; m_left <= nl; m_wait <= nw; m_new <= nn;
        m_rv <= nrv; m_rd <= nrd;
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        int exp_stb;
        if (m_ok) begin
            exp_stb = (rst_n && m_new && m_state != 1) ? (1 << m_state) : 0;
            chk("cyc_state", int'(state), m_state);
            chk("cyc_strobes", int'(dut_stb), exp_stb);
            chk("cyc_halted", int'(halted), (rst_n && m_state == 1) ? 1 : 0);
            chk("cyc_rvalid", int'(bus_rvalid), int'(m_rv));
            chk("cyc_rdata", int'(bus_rdata), m_rd);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
        bus_write = 1'b1; bus_addr = a; bus_wdata = d;
        tick();
        bus_write = 1'b0; bus_addr = 8'h00; bus_wdata = 8'h00;
    endtask

    task automatic wait_state(input int s, input string nm);
        int n = 0;
        while (int'(state) != s && n < 300) begin tick(); n++; end
        if (n >= 300) chk(nm, int'(state), s);
    endtask

    task automatic measure_load(input int ready_at, output int len, output int pulses);
        int n = 0;
        bit done = 1'b0;
        len = 0; pulses = 0;
        mem_ready = (ready_at == 0);
        while (!done && n < 400) begin
            @(negedge clk);
            if (int'(state) == 6) begin
                len++; pulses += int'(do_memload);
            end else if (len > 0) begin
                done = 1'b1;
            end
            tick(); n++;
            if (len > 0) mem_ready = (len >= ready_at);
        end
        if (!done) chk("load_timeout", 0, 1);
        mem_ready = 1'b1;
    endtask

    int st [7];
    int rs [7], fe [7], al [7];
    int exp1 [7] = '{0, 2, 3, 4, 5, 8, 2};
    int len, pulses, bad, cnt_next, cnt_mem, cnt_rs, n;

    initial begin
        // Test 1: reset release into the ALU path.
        rst_n = 1'b0; isaluop = 1'b1; opcode = OP_LOAD; mem_ready = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("reset_state", int'(state), 0);
        chk("reset_rvalid", int'(bus_rvalid), 0);
        chk("reset_strobes", int'(dut_stb), 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            st[i] = int'(state); rs[i] = int'(do_reset);
            fe[i] = int'(do_fetch); al[i] = int'(do_aluop);
            tick();
        end
        for (int i = 0; i < 7; i++) chk($sformatf("t1_state_c%0d", i), st[i], exp1[i]);
        chk("t1_do_reset_c0", rs[0], 1); chk("t1_do_reset_c1", rs[1], 0);
        chk("t1_do_fetch_c1", fe[1], 1); chk("t1_do_fetch_c2", fe[2], 0);
        chk("t1_do_aluop_c3", al[3], 1); chk("t1_do_aluop_c4", al[4], 0);

        // Test 2: dwell of 3 on LOAD, then an extra mem_ready stall.
        isaluop = 1'b0; opcode = OP_LOAD;
        bus_wr(8'hF1, 8'd3);
        tick();
        wait_state(2, "t2_reach_fetch");
        measure_load(0, len, pulses);
        chk("t2_load_len_dwell", len, 4);
        chk("t2_memload_pulses", pulses, 1);
        measure_load(9, len, pulses);
        chk("t2_load_len_stall", len, 10);
        chk("t2_memload_pulses_stall", pulses, 1);

        // Test 3: unknown opcode halts until a bus write releases it.
        bus_wr(8'hF1, 8'd0);
        opcode = 4'hF;
        n = 0;
        while (!halted && n < 300) begin tick(); n++; end
        chk("t3_halted", int'(halted), 1);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (int'(state) != 1 || !halted) bad++;
            tick();
        end
        chk("t3_halt_hold", bad, 0);
        bus_wr(8'hF0, 8'h02);
        @(negedge clk);
        chk("t3_wr_state", int'(state), 2);
        chk("t3_do_fetch", int'(do_fetch), 1);
        tick();

        // Test 4: invalid encoding parks in HALT; read back.
        bus_wr(8'hF0, 8'h0C);
        @(negedge clk);
        chk("t4_state_halt", int'(state), 1);
        bus_read = 1'b1; bus_addr = 8'hF0;
        tick();
        bus_read = 1'b0; bus_addr = 8'h00;
        @(negedge clk);
        chk("t4_rvalid", int'(bus_rvalid), 1);
        chk("t4_rdata", int'(bus_rdata), 1);
        tick();
        @(negedge clk);
        chk("t4_rvalid_drop", int'(bus_rvalid), 0);

        // Test 5: reset during a STORE stall with a competing bus write.
        opcode = OP_STORE; mem_ready = 1'b0;
        bus_wr(8'hF1, 8'd5);
        bus_wr(8'hF0, 8'h03);
        wait_state(7, "t5_reach_store");
        tick(); tick(); tick();
        rst_n = 1'b0; bus_write = 1'b1; bus_addr = 8'hF0; bus_wdata = 8'h04;
        @(negedge clk);
        chk("t5_strobes_in_reset", int'(dut_stb), 0);
        tick();
        rst_n = 1'b1; bus_write = 1'b0; bus_addr = 8'h00; bus_wdata = 8'h00;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("t5_state_reset", int'(state), 0);
        chk("t5_do_reset", int'(do_reset), 1);
        bus_read = 1'b1; bus_addr = 8'hF1;
        tick();
        bus_read = 1'b0; bus_addr = 8'h00;
        @(negedge clk);
        chk("t5_wait_default", int'(bus_rdata), DEF_WAIT);
        chk("t5_wait_rvalid", int'(bus_rvalid), 1);
        tick();

        // Test 6: JMP path, reset held two cycles to show strobe masking.
        opcode = OP_JMP; isaluop = 1'b0; rst_n = 1'b0;
        tick();
        @(negedge clk);
        chk("t6_masked_do_reset", int'(do_reset), 0);
        tick();
        rst_n = 1'b1;
        cnt_next = 0; cnt_mem = 0; cnt_rs = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            st[i] = int'(state);
            cnt_next += int'(do_next);
            cnt_mem += int'(do_memload) + int'(do_memstore);
            cnt_rs += int'(do_regstore);
            tick();
        end
        chk("t6_state_regload", st[2], 3);
        chk("t6_state_next", st[3], 8);
        chk("t6_state_fetch", st[4], 2);
        chk("t6_next_count", cnt_next, 1);
        chk("t6_mem_strobes", cnt_mem, 0);
        chk("t6_regstore_count", cnt_rs, 0);

        // Random phase: the compare process checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 63) != 0);
            opcode    = 4'($urandom_range(0, 15));
            isaluop   = ($urandom_range(0, 3) == 0);
            mem_ready = ($urandom_range(0, 3) != 0);
            bus_read  = ($urandom_range(0, 3) == 0);
            bus_write = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 2))
                0: bus_addr = 8'hF0;
                1: bus_addr = 8'hF1;
                default: bus_addr = 8'($urandom_range(0, 255));
            endcase
            if (bus_addr == 8'hF1) bus_wdata = 8'($urandom_range(0, 3));
            else bus_wdata = 8'($urandom_range(0, 255));
            tick();
        end
        rst_n = 1'b1; bus_read = 1'b0; bus_write = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
